// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV M-extension multiply/divide unit:
// funct3 encodings, FSM states and a conditional two's-complement negate.
package muldiv_pkg;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   // Wide enough for the 2*XLEN product at XLEN=64; callers zero-extend and slice.
   localparam int MAXW = 128;

   function automatic logic [MAXW-1:0] cneg(input logic [MAXW-1:0] v, input logic neg);
      return neg ? (~v + MAXW'(1)) : v;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply/divide for RV M ops: shift-add multiply, restoring
// divide, sign fix-up in FIX, RISC-V divide special cases resolved at accept.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] x,
   input  logic [XLEN-1:0] y,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out
);

   localparam int CW = $clog2(XLEN+1);

   state_t            state_q, state_d;
   logic [2:0]        op_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   mcand_q;     // |x| for multiply, divisor magnitude for divide
   logic [XLEN-1:0]   quo_q;
   logic [XLEN:0]     rem_q;
   logic              neg_res_q, neg_rem_q;
   logic [CW-1:0]     cnt_q;

   logic              is_div, sgn_x, sgn_y, neg_x, neg_y, special;
   logic [XLEN-1:0]   mag_x, mag_y, spec_res, fix_res;
   logic [MAXW-1:0]   tmp_x, tmp_y, prod_t, quo_t, rem_t;
   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN+1:0]   div_diff;
   logic              div_ge;
   logic              unused_bits;

   assign in_ready = (state_q == IDLE);

   always_comb begin
      is_div   = funct3[2];
      sgn_x    = (funct3 == MULH) || (funct3 == MULHSU) || (funct3 == DIV) || (funct3 == REM);
      sgn_y    = (funct3 == MULH) || (funct3 == DIV) || (funct3 == REM);
      neg_x    = sgn_x & x[XLEN-1];
      neg_y    = sgn_y & y[XLEN-1];
      tmp_x    = cneg(MAXW'(x), neg_x);
      tmp_y    = cneg(MAXW'(y), neg_y);
      mag_x    = tmp_x[XLEN-1:0];
      mag_y    = tmp_y[XLEN-1:0];
      spec_res = '0;
      special  = 1'b0;
      if (is_div && (y == '0)) begin
         special  = 1'b1;
         spec_res = funct3[1] ? x : '1;
      end else if (is_div && sgn_y && (x == {1'b1, {(XLEN-1){1'b0}}}) && (y == '1)) begin
         special  = 1'b1;
         spec_res = funct3[1] ? '0 : x;
      end

      // One iteration of each algorithm; only the one matching op_q is committed.
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      div_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
      div_ge    = ~div_diff[XLEN+1];

      prod_t = cneg(MAXW'(acc_q), neg_res_q);
      quo_t  = cneg(MAXW'(quo_q), neg_res_q);
      rem_t  = cneg(MAXW'(rem_q[XLEN-1:0]), neg_rem_q);
      unique case (op_q)
         MUL:                fix_res = prod_t[XLEN-1:0];
         MULH, MULHSU, MULHU: fix_res = prod_t[2*XLEN-1:XLEN];
         DIV, DIVU:          fix_res = quo_t[XLEN-1:0];
         default:            fix_res = rem_t[XLEN-1:0];
      endcase

      unused_bits = ^{tmp_x[MAXW-1:XLEN], tmp_y[MAXW-1:XLEN], prod_t[MAXW-1:2*XLEN],
                      quo_t[MAXW-1:XLEN], rem_t[MAXW-1:XLEN], rem_q[XLEN]};
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = special ? DONE : CALC;
         CALC:    if (cnt_q == '0) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    if (out_valid && out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         op_q      <= MUL;
         acc_q     <= '0;
         mcand_q   <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: if (in_valid) begin
               op_q      <= funct3;
               neg_res_q <= neg_x ^ neg_y;
               neg_rem_q <= neg_x;
               cnt_q     <= CW'(XLEN-1);
               mcand_q   <= is_div ? mag_y : mag_x;
               acc_q     <= {{XLEN{1'b0}}, mag_y};
               quo_q     <= mag_x;
               rem_q     <= '0;
               if (special) out <= spec_res;
            end
            CALC: begin
               if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
               if (op_q[2]) begin
                  rem_q <= div_ge ? div_diff[XLEN:0] : div_shift;
                  quo_q <= {quo_q[XLEN-2:0], div_ge};
               end else begin
                  acc_q <= {mul_sum, acc_q[XLEN-1:1]};
               end
            end
            FIX:  out <= fix_res;
            // out_valid trails entry into DONE by one cycle and drops on handoff.
            DONE: out_valid <= !(out_valid && out_ready);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed plus randomized checks of muldiv_iter (XLEN=32) against an
// arithmetic reference model of the RV M-extension semantics.
module tb_muldiv_iter;

   logic        clk, resetn, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  funct3;
   logic [31:0] x, y, out;
   int          checks = 0;
   int          errors = 0;

   muldiv_iter #(.XLEN(32)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .funct3(funct3), .x(x), .y(y), .out_valid(out_valid),
      .out_ready(out_ready), .out(out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      int              qi;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            qi = $signed(a) / $signed(b); return qi;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            qi = $signed(a) % $signed(b); return qi;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Called at #1 after a rising edge with the unit idle; leaves it idle again.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
      int lat;
      int exp_lat;
      exp_lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
      in_valid = 1'b1; funct3 = f; x = a; y = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_out"}, 64'(out), 64'(model(f, a, b)));
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat;
      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; funct3 = 3'd0; x = '0; y = '0;
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_neg");
      chk("mul_neg_const", 64'(out), 64'hFFFF_FFEB);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
      chk("mulhu_const", 64'(out), 64'hFFFF_FFFE);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
      chk("mulh_const", 64'(out), 64'h4000_0000);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
      chk("mulhsu_const", 64'(out), 64'hFFFF_FFFF);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg");
      chk("div_neg_const", 64'(out), 64'hFFFF_FFFD);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg");
      chk("rem_neg_const", 64'(out), 64'hFFFF_FFFF);
      run_op(3'd5, 32'd7, 32'd2, "divu");
      run_op(3'd7, 32'd7, 32'd2, "remu");
      run_op(3'd4, 32'd5, 32'd0, "div_by0");
      chk("div_by0_const", 64'(out), 64'hFFFF_FFFF);
      run_op(3'd7, 32'd5, 32'd0, "remu_by0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      chk("div_ovf_const", 64'(out), 64'h8000_0000);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

      // Backpressure: result held, requests refused while DONE.
      in_valid = 1'b1; funct3 = 3'd5; x = 32'd100; y = 32'd7;
      @(posedge clk); #1;
      funct3 = 3'd0; x = 32'd1; y = 32'd1;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_out_stable", 64'(out), 64'd14);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_idle_ready", 64'(in_ready), 64'd1);
      chk("bp_idle_valid", 64'(out_valid), 64'd0);
      run_op(3'd0, 32'd5, 32'd6, "bp_next");

      // Reset in the middle of CALC abandons the operation.
      in_valid = 1'b1; funct3 = 3'd0; x = 32'h1234_5678; y = 32'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_ready", 64'(in_ready), 64'd1);
      chk("midrst_out", 64'(out), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      run_op(3'd0, 32'd3, 32'd4, "mul_after_rst");
      chk("mul_after_rst_const", 64'(out), 64'd12);

      for (int i = 0; i < 48; i++) begin
         logic [2:0]  f;
         logic [31:0] a, b;
         f = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         run_op(f, a, b, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
